mips_cpu_hilo_unit: RTL and testbench



---
 rtl/mips_cpu_hilo_unit.sv | 136 +++++++++++++
 tb/tb_mips_cpu_hilo_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO register file for the MIPS core: captures multiply/move results, serves
// MFHI/MFLO, and runs DIV/DIVU on a 32-step restoring divider that stalls the core.
module mips_cpu_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata_hi,
   input  logic [WIDTH-1:0] wdata_lo,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             rd_hi,
   input  logic             rd_lo,
   output logic [WIDTH-1:0] rdata,
   output logic             busy,
   output logic             stall,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic [WIDTH-1:0] quo_reg, dvs_reg;
   logic [WIDTH:0]   rem_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             q_sign_reg, r_sign_reg, dz_reg;
   logic             busy_reg, div_by_zero_reg;

   logic             dvd_neg, dvs_neg, divisor_zero;
   logic [WIDTH-1:0] dvd_abs, dvs_abs;
   logic [WIDTH:0]   rem_shift, rem_diff;
   logic             borrow, last_step, dz_hold;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign dvd_neg      = div_signed & dividend[WIDTH-1];
   assign dvs_neg      = div_signed & divisor[WIDTH-1];
   assign dvd_abs      = dvd_neg ? -dividend : dividend;
   assign dvs_abs      = dvs_neg ? -divisor : divisor;
   assign divisor_zero = (divisor == '0);

   // quo_reg doubles as the dividend shifter: its MSB feeds the remainder while
   // quotient bits enter from the bottom.
   assign rem_shift = (rem_reg << 1) | {{WIDTH{1'b0}}, quo_reg[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, dvs_reg};
   assign borrow    = rem_diff[WIDTH];
   assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

   assign quo_fix = q_sign_reg ? -quo_reg : quo_reg;
   assign rem_fix = r_sign_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

   // A zero-divisor result is held in FIX for one extra cycle so busy spans two cycles.
   assign dz_hold = dz_reg & (cnt_reg == '0);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (div_start) state_next = divisor_zero ? FIX : DIV;
         DIV:     if (last_step) state_next = FIX;
         FIX:     if (!dz_hold)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         hi_reg          <= '0;
         lo_reg          <= '0;
         quo_reg         <= '0;
         dvs_reg         <= '0;
         rem_reg         <= '0;
         cnt_reg         <= '0;
         q_sign_reg      <= 1'b0;
         r_sign_reg      <= 1'b0;
         dz_reg          <= 1'b0;
         busy_reg        <= 1'b0;
         div_by_zero_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next != IDLE);
         case (state_reg)
            IDLE: begin
               if (div_start) begin
                  quo_reg         <= divisor_zero ? dividend : dvd_abs;
                  dvs_reg         <= dvs_abs;
                  rem_reg         <= '0;
                  cnt_reg         <= '0;
                  q_sign_reg      <= dvd_neg ^ dvs_neg;
                  r_sign_reg      <= dvd_neg;
                  dz_reg          <= divisor_zero;
                  div_by_zero_reg <= 1'b0;
               end else begin
                  if (wr_hi) hi_reg <= wdata_hi;
                  if (wr_lo) lo_reg <= wdata_lo;
               end
            end
            DIV: begin
               rem_reg <= borrow ? rem_shift : rem_diff;
               quo_reg <= {quo_reg[WIDTH-2:0], ~borrow};
               cnt_reg <= cnt_reg + 1'b1;
            end
            FIX: begin
               if (dz_hold) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end else if (dz_reg) begin
                  lo_reg          <= '1;
                  hi_reg          <= quo_reg;
                  div_by_zero_reg <= 1'b1;
               end else begin
                  lo_reg <= quo_fix;
                  hi_reg <= rem_fix;
               end
            end
            default: ;
         endcase
      end
   end

   // Same-cycle write data is forwarded so a read right behind a write sees it.
   always_comb begin
      rdata = '0;
      if (rd_hi)      rdata = wr_hi ? wdata_hi : hi_reg;
      else if (rd_lo) rdata = wr_lo ? wdata_lo : lo_reg;
   end

   assign busy        = busy_reg;
   assign stall       = busy_reg & (rd_hi | rd_lo | wr_hi | wr_lo | div_start);
   assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Randomized bench for mips_cpu_hilo_unit: a transaction-level HI/LO/divide model
// is compared against the DUT every cycle, plus directed literal checks.
module tb_mips_cpu_hilo_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_hi = 1'b0, wr_lo = 1'b0;
   logic [31:0] wdata_hi = '0, wdata_lo = '0;
   logic        div_start = 1'b0, div_signed = 1'b0;
   logic [31:0] dividend = '0, divisor = '0;
   logic        rd_hi = 1'b0, rd_lo = 1'b0;
   logic [31:0] rdata;
   logic        busy, stall, div_by_zero;

   mips_cpu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata_hi(wdata_hi), .wdata_lo(wdata_lo),
      .div_start(div_start), .div_signed(div_signed),
      .dividend(dividend), .divisor(divisor),
      .rd_hi(rd_hi), .rd_lo(rd_lo),
      .rdata(rdata), .busy(busy), .stall(stall), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a divide is a result computed up front plus a busy countdown.
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          m_dz, p_dz;
   int          m_cnt;
   longint      sa, sb, sq, sr;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_hi = '0; m_lo = '0; m_dz = 1'b0; m_cnt = 0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_hi = p_hi; m_lo = p_lo;
            if (p_dz) m_dz = 1'b1;
         end
      end else if (div_start) begin
         if (divisor == 0) begin
            p_lo = 32'hFFFF_FFFF; p_hi = dividend; p_dz = 1'b1;
         end else begin
            p_dz = 1'b0;
            if (div_signed) begin
               sa = longint'($signed(dividend));
               sb = longint'($signed(divisor));
            end else begin
               sa = longint'({32'h0, dividend});
               sb = longint'({32'h0, divisor});
            end
            sq = sa / sb;
            sr = sa % sb;
            p_lo = 32'(sq);
            p_hi = 32'(sr);
         end
         m_dz  = 1'b0;
         m_cnt = (divisor == 0) ? 2 : 33;
      end else begin
         if (wr_hi) m_hi = wdata_hi;
         if (wr_lo) m_lo = wdata_lo;
      end
   end

   function automatic logic [31:0] exp_rdata();
      if (rd_hi) return wr_hi ? wdata_hi : m_hi;
      if (rd_lo) return wr_lo ? wdata_lo : m_lo;
      return 32'h0;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         logic exp_busy, exp_stall;
         exp_busy  = (m_cnt > 0);
         exp_stall = exp_busy & (rd_hi | rd_lo | wr_hi | wr_lo | div_start);
         chk("busy", {31'h0, busy}, {31'h0, exp_busy});
         chk("stall", {31'h0, stall}, {31'h0, exp_stall});
         chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, m_dz});
         if (!exp_stall) chk("rdata", rdata, exp_rdata());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(input bit hi, input logic [31:0] exp, input string name);
      rd_hi = hi; rd_lo = !hi;
      @(negedge clk);
      chk(name, rdata, exp);
      $display("read %s rdata=%h", hi ? "HI" : "LO", rdata);
      step();
      rd_hi = 1'b0; rd_lo = 1'b0;
   endtask

   // Issues a divide, holds an MFLO request while busy, returns cycles busy was high.
   task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles);
      int cnt;
      div_start = 1'b1; div_signed = sgn; dividend = a; divisor = b;
      step();
      div_start = 1'b0;
      rd_lo = 1'b1;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         step();
      end
      rd_lo = 1'b0;
      if (cnt >= 100) chk("div_timeout", 32'(cnt), 32'd33);
      busy_cycles = cnt;
      $display("div %s %h/%h busy=%0d", sgn ? "DIV" : "DIVU", a, b, cnt);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      // 1: reset after arbitrary writes
      step(); step();
      rst_n = 1'b1;
      cmp_en = 1'b1;
      wr_hi = 1'b1; wr_lo = 1'b1; wdata_hi = 32'hDEAD_BEEF; wdata_lo = 32'hCAFE_F00D;
      step();
      wr_hi = 1'b0; wr_lo = 1'b0;
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_dbz", {31'h0, div_by_zero}, 32'h0);
      read_chk(1'b1, 32'h0, "rst_hi");
      read_chk(1'b0, 32'h0, "rst_lo");

      // 2: MULTU result capture and same-cycle forwarding
      wr_hi = 1'b1; wr_lo = 1'b1; wdata_hi = 32'h5; wdata_lo = 32'h0;
      step();
      wr_hi = 1'b0; wr_lo = 1'b0;
      read_chk(1'b1, 32'h5, "multu_hi");
      read_chk(1'b0, 32'h0, "multu_lo");
      wr_hi = 1'b1; wdata_hi = 32'h1234; rd_hi = 1'b1;
      @(negedge clk);
      chk("fwd_hi", rdata, 32'h1234);
      step();
      wr_hi = 1'b0; rd_hi = 1'b0;

      // 3: DIVU 100/7
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
      step();
      div_start = 1'b0; rd_lo = 1'b1;
      @(negedge clk);
      chk("stall_busy", {31'h0, stall}, 32'h1);
      bc = 1;
      step();
      while (busy === 1'b1 && bc < 100) begin bc++; step(); end
      rd_lo = 1'b0;
      chk("divu_busy_len", 32'(bc), 32'd33);
      read_chk(1'b0, 32'h0000_000E, "divu_lo");
      read_chk(1'b1, 32'h0000_0002, "divu_hi");

      // 4: signed divides, including the overflow case
      do_div(1'b1, 32'hFFFF_FFF9, 32'h2, bc);
      read_chk(1'b0, 32'hFFFF_FFFD, "div_m7_2_lo");
      read_chk(1'b1, 32'hFFFF_FFFF, "div_m7_2_hi");
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, bc);
      read_chk(1'b0, 32'h8000_0000, "div_ovf_lo");
      read_chk(1'b1, 32'h0, "div_ovf_hi");

      // 5: divide by zero and its clearing
      do_div(1'b0, 32'h10, 32'h0, bc);
      chk("dz_busy_len", 32'(bc), 32'd2);
      chk("dz_flag", {31'h0, div_by_zero}, 32'h1);
      read_chk(1'b0, 32'hFFFF_FFFF, "dz_lo");
      read_chk(1'b1, 32'h10, "dz_hi");
      do_div(1'b0, 32'd9, 32'd3, bc);
      chk("dz_cleared", {31'h0, div_by_zero}, 32'h0);
      read_chk(1'b0, 32'h3, "div9_3_lo");
      read_chk(1'b1, 32'h0, "div9_3_hi");

      // 6: reset in the middle of a divide
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
      step();
      div_start = 1'b0;
      repeat (10) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      read_chk(1'b1, 32'h0, "midrst_hi");
      read_chk(1'b0, 32'h0, "midrst_lo");
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
      step();
      div_start = 1'b0;
      chk("restart_busy", {31'h0, busy}, 32'h1);
      bc = 0;
      while (busy === 1'b1 && bc < 100) begin bc++; step(); end
      read_chk(1'b0, 32'h3, "restart_lo");

      // Randomized traffic checked cycle-by-cycle against the model
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(0, 299) != 0);
         div_start  = ($urandom_range(0, 14) == 0);
         div_signed = $urandom_range(0, 1);
         dividend   = pick_operand();
         divisor    = pick_operand();
         wr_hi      = !div_start && ($urandom_range(0, 5) == 0);
         wr_lo      = !div_start && ($urandom_range(0, 5) == 0);
         wdata_hi   = $urandom;
         wdata_lo   = $urandom;
         rd_hi      = $urandom_range(0, 2) == 0;
         rd_lo      = $urandom_range(0, 2) == 0;
         step();
      end
      rst_n = 1'b1; div_start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; rd_hi = 1'b0; rd_lo = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
